// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: flag register, condition evaluation, target add and a
// one-cycle registered resolution with wrong-path squash. Define BRANCH_PRED_EN for the 2-bit BHT.
module branch_resolve_unit #(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 9,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flag_we,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              n_in,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              br_pred_taken,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic [ADDR_W-1:0] res_target,
  output logic              mispredict,
  output logic [2:0]        flags_q
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef struct packed {
    logic              valid;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              mispredict;
  } res_t;

  res_t              res_q, res_d;
  logic [2:0]        flags_d;
  logic              squash_q, squash_d;
  logic [2:0]        eff_flags;
  logic              cond_taken;
  logic              accept;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;

  // Same-cycle flag writes are forwarded into the condition check.
  assign eff_flags = flag_we ? {z_in, v_in, n_in} : flags_q;
  assign accept    = br_valid & ~stall & ~squash_q;
  assign off_ext   = ADDR_W'($signed(br_off));
  assign target    = br_pc + off_ext + ADDR_W'(1);

  always_comb begin
    cond_taken = 1'b0;
    case (br_cond)
      3'b000: cond_taken = !eff_flags[2];
      3'b001: cond_taken = eff_flags[2];
      3'b010: cond_taken = !eff_flags[0] && !eff_flags[2];
      3'b011: cond_taken = eff_flags[0];
      3'b100: cond_taken = eff_flags[2] || !eff_flags[0];
      3'b101: cond_taken = eff_flags[0] || eff_flags[2];
      3'b110: cond_taken = eff_flags[1];
      3'b111: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    res_d    = res_q;
    squash_d = squash_q;
    if (!stall) begin
      if (flag_we) flags_d = {z_in, v_in, n_in};
      res_d.valid      = accept;
      res_d.mispredict = accept & (cond_taken ^ br_pred_taken);
      if (accept) begin
        res_d.taken  = cond_taken;
        res_d.target = target;
      end
      // Squash covers the cycle in which mispredict is visible downstream.
      squash_d = res_d.mispredict;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      res_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      res_q    <= res_d;
      squash_q <= squash_d;
    end
  end

  assign res_valid  = res_q.valid;
  assign res_taken  = res_q.taken;
  assign res_target = res_q.target;
  assign mispredict = res_q.mispredict;

`ifdef BRANCH_PRED_EN
  logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
  logic [IDX_W-1:0]          upd_idx;

  assign upd_idx = br_pc[IDX_W-1:0];

  always_comb begin
    bht_d = bht_q;
    if (accept) begin
      if (cond_taken && bht_q[upd_idx] != 2'b11)
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      else if (!cond_taken && bht_q[upd_idx] != 2'b00)
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bht_q <= {BHT_DEPTH{2'b01}};
    else        bht_q <= bht_d;
  end

  // Reads the registered table, so a same-index update shows up next cycle.
  assign pred_taken = bht_q[fetch_pc[IDX_W-1:0]][1];
`else
  assign pred_taken = 1'b0;
`endif

  logic unused_fetch;
  assign unused_fetch = ^fetch_pc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus hand sequences for reset, squash, stall and BHT.
module tb_branch_resolve_unit;
  localparam int ADDR_W = 16, OFF_W = 9, BHT_DEPTH = 16;
`ifdef BRANCH_PRED_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
  logic              flag_we = 1'b0, z_in = 1'b0, v_in = 1'b0, n_in = 1'b0;
  logic              br_valid = 1'b0, br_pred_taken = 1'b0;
  logic [2:0]        br_cond = 3'b000;
  logic [ADDR_W-1:0] br_pc = '0, fetch_pc = '0;
  logic [OFF_W-1:0]  br_off = '0;
  logic              pred_taken, res_valid, res_taken, mispredict;
  logic [ADDR_W-1:0] res_target;
  logic [2:0]        flags_q;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .BHT_DEPTH(BHT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .z_in(z_in), .v_in(v_in), .n_in(n_in), .br_valid(br_valid),
    .br_cond(br_cond), .br_pc(br_pc), .br_off(br_off),
    .br_pred_taken(br_pred_taken), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .mispredict(mispredict), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  typedef struct {
    logic        we;
    logic [2:0]  zvn;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [8:0]  off;
    logic        pred;
    logic        exp_taken;
    logic [15:0] exp_tgt;
    logic        exp_mis;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off, input logic p);
    br_valid = 1'b1; br_cond = c; br_pc = pc; br_off = off; br_pred_taken = p;
  endtask

  task automatic idle;
    br_valid = 1'b0; flag_we = 1'b0;
  endtask

  initial begin
    //          we   zvn     cond    pc        off     pred  taken tgt       mis   flags
    tbl[0] = '{1'b0, 3'b100, 3'b000, 16'h0020, 9'h000, 1'b0, 1'b0, 16'h0021, 1'b0, 3'b100};
    tbl[1] = '{1'b1, 3'b000, 3'b010, 16'h0100, 9'h1FF, 1'b1, 1'b1, 16'h0100, 1'b0, 3'b000};
    tbl[2] = '{1'b1, 3'b001, 3'b011, 16'h0040, 9'h010, 1'b0, 1'b1, 16'h0051, 1'b1, 3'b001};
    tbl[3] = '{1'b0, 3'b000, 3'b100, 16'h0200, 9'h100, 1'b1, 1'b0, 16'h0101, 1'b1, 3'b001};
    tbl[4] = '{1'b0, 3'b000, 3'b101, 16'h1234, 9'h0FF, 1'b1, 1'b1, 16'h1334, 1'b0, 3'b001};
    tbl[5] = '{1'b1, 3'b010, 3'b110, 16'h0005, 9'h002, 1'b0, 1'b1, 16'h0008, 1'b1, 3'b010};
    tbl[6] = '{1'b1, 3'b000, 3'b110, 16'h0007, 9'h000, 1'b0, 1'b0, 16'h0008, 1'b0, 3'b000};
    tbl[7] = '{1'b0, 3'b000, 3'b111, 16'hFFFE, 9'h001, 1'b1, 1'b1, 16'h0000, 1'b0, 3'b000};
    tbl[8] = '{1'b0, 3'b000, 3'b000, 16'h0000, 9'h100, 1'b0, 1'b1, 16'hFF01, 1'b1, 3'b000};
    tbl[9] = '{1'b1, 3'b101, 3'b100, 16'h00F0, 9'h00F, 1'b1, 1'b1, 16'h0100, 1'b0, 3'b101};

    // Reset state
    step; step;
    chk("rst_valid", res_valid, 0); chk("rst_taken", res_taken, 0);
    chk("rst_target", res_target, 0); chk("rst_mis", mispredict, 0);
    chk("rst_flags", flags_q, 0); chk("rst_pred", pred_taken, 0);

    // Branch accepted on the first edge after release
    rst_n = 1'b1;
    br(3'b111, 16'h0000, 9'h000, 1'b1);
    step;
    chk("first_valid", res_valid, 1); chk("first_tgt", res_target, 16'h0001);
    chk("first_mis", mispredict, 0);

    // Flag write, then z-branch that mispredicts
    idle; flag_we = 1'b1; {z_in, v_in, n_in} = 3'b100;
    step;
    chk("fw_flags", flags_q, 3'b100); chk("fw_idle_valid", res_valid, 0);
    chk("fw_hold_tgt", res_target, 16'h0001);
    flag_we = 1'b0;
    br(3'b001, 16'h0010, 9'h005, 1'b0);
    step;
    chk("z_valid", res_valid, 1); chk("z_taken", res_taken, 1);
    chk("z_tgt", res_target, 16'h0016); chk("z_mis", mispredict, 1);

    // Wrong-path branch during mispredict cycle is dropped
    br(3'b111, 16'h0003, 9'h000, 1'b0);
    fetch_pc = 16'h0003;
    step;
    chk("sq_valid", res_valid, 0); chk("sq_mis", mispredict, 0);
    chk("sq_tgt_hold", res_target, 16'h0016);
    chk("sq_bht_idx3", pred_taken, 0);
    fetch_pc = 16'h0010;
    #1 chk("bht_idx0", pred_taken, PE ? 1 : 0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      flag_we = tbl[i].we; {z_in, v_in, n_in} = tbl[i].zvn;
      br(tbl[i].cond, tbl[i].pc, tbl[i].off, tbl[i].pred);
      step;
      chk($sformatf("v%0d_valid", i), res_valid, 1);
      chk($sformatf("v%0d_taken", i), res_taken, tbl[i].exp_taken);
      chk($sformatf("v%0d_tgt", i), res_target, tbl[i].exp_tgt);
      chk($sformatf("v%0d_mis", i), mispredict, tbl[i].exp_mis);
      chk($sformatf("v%0d_flags", i), flags_q, tbl[i].exp_flags);
      idle;
      step;
      chk($sformatf("v%0d_idle_valid", i), res_valid, 0);
      chk($sformatf("v%0d_idle_mis", i), mispredict, 0);
      chk($sformatf("v%0d_idle_tgt", i), res_target, tbl[i].exp_tgt);
    end

    // BHT saturating counter at index 3 (fetch via alias 0x0013)
    fetch_pc = 16'h0013;
    br(3'b111, 16'h0003, 9'h000, 1'b1);
    #1 chk("bht_preupd", pred_taken, 0);
    step; chk("bht_inc1", pred_taken, PE ? 1 : 0); chk("bht_inc1_mis", mispredict, 0);
    step; chk("bht_inc2", pred_taken, PE ? 1 : 0);
    step; chk("bht_inc3", pred_taken, PE ? 1 : 0); chk("bht_inc3_valid", res_valid, 1);
    br(3'b000, 16'h0003, 9'h000, 1'b0);
    step; chk("bht_dec1", pred_taken, PE ? 1 : 0); chk("bht_dec1_taken", res_taken, 0);
    step; chk("bht_dec2", pred_taken, 0);

    // Squash persists across stall; stall holds outputs and flags
    br(3'b001, 16'h0030, 9'h002, 1'b0);
    step;
    chk("st_mis", mispredict, 1); chk("st_tgt", res_target, 16'h0033);
    stall = 1'b1; br(3'b111, 16'h0050, 9'h000, 1'b1);
    flag_we = 1'b1; {z_in, v_in, n_in} = 3'b010;
    step;
    chk("st_hold_valid", res_valid, 1); chk("st_hold_mis", mispredict, 1);
    chk("st_hold_flags", flags_q, 3'b101);
    step;
    chk("st_hold2_tgt", res_target, 16'h0033);
    stall = 1'b0; flag_we = 1'b0;
    step;
    chk("st_sq_valid", res_valid, 0); chk("st_sq_mis", mispredict, 0);
    step;
    chk("st_after_valid", res_valid, 1); chk("st_after_tgt", res_target, 16'h0051);

    // Reset asserted mid-stall clears outputs immediately
    stall = 1'b1;
    step;
    chk("pre_rst_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0); chk("arst_taken", res_taken, 0);
    chk("arst_tgt", res_target, 0); chk("arst_mis", mispredict, 0);
    chk("arst_flags", flags_q, 0);

    // Branch in flight at reset produces nothing after release
    stall = 1'b0;
    step;
    rst_n = 1'b1; idle;
    step;
    chk("inflight_valid", res_valid, 0); chk("inflight_tgt", res_target, 0);
    chk("rst_bht", pred_taken, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
